seq_div: RTL

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/seq_div.sv | 121 ++++++++++++
 1 files changed

// File: rtl/seq_div.sv
// Sequential 8-by-4 unsigned restoring divider: one quotient bit per cycle, valid/ready on both sides.
// Define SEQ_DIV_DIVZERO_EN to send zero divisors straight to DONE and flag them on io_out_divzero.
module seq_div (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_in_valid,
    output logic       io_in_ready,
    input  logic [7:0] io_in_dividend,
    input  logic [3:0] io_in_divisor,
    output logic       io_out_valid,
    input  logic       io_out_ready,
    output logic [7:0] io_out_quotient,
    output logic [3:0] io_out_remainder,
    output logic       io_out_divzero
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // io_in_ready is 1 only in IDLE; io_out_valid is 1 only in DONE and holds until io_out_ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] work;
    logic [3:0] divisor;
    logic [3:0] rem;
    logic [2:0] count;

    logic [4:0] trial;
    logic [3:0] diff;
    logic       fits;
    logic [3:0] next_rem;
    logic [7:0] next_work;

    // Partial remainder stays below the divisor, so its fifth bit is always zero and is
    // not stored. The difference is taken mod 16, exact whenever the subtraction is kept.
    always_comb begin
        trial     = {rem, work[7]};
        fits      = (trial >= {1'b0, divisor});
        diff      = trial[3:0] - divisor;
        next_rem  = fits ? diff : trial[3:0];
        next_work = {work[6:0], fits};
    end

`ifdef SEQ_DIV_DIVZERO_EN
    logic divzero;
    assign io_out_divzero = divzero;
`else
    assign io_out_divzero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            io_in_ready      <= 1'b1;
            io_out_valid     <= 1'b0;
            io_out_quotient  <= 8'h00;
            io_out_remainder <= 4'h0;
            work             <= 8'h00;
            divisor          <= 4'h0;
            rem              <= 4'h0;
            count            <= 3'd0;
`ifdef SEQ_DIV_DIVZERO_EN
            divzero          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (io_in_valid) begin
                        work        <= io_in_dividend;
                        divisor     <= io_in_divisor;
                        rem         <= 4'h0;
                        count       <= 3'd7;
                        io_in_ready <= 1'b0;
`ifdef SEQ_DIV_DIVZERO_EN
                        if (io_in_divisor == 4'h0) begin
                            state            <= DONE;
                            io_out_valid     <= 1'b1;
                            io_out_quotient  <= 8'hFF;
                            io_out_remainder <= io_in_dividend[3:0];
                            divzero          <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
`else
                        state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    // work shifts dividend bits out at the top and quotient bits in at the bottom
                    work  <= next_work;
                    rem   <= next_rem;
                    count <= count - 3'd1;
                    if (count == 3'd0) begin
                        state            <= DONE;
                        io_out_valid     <= 1'b1;
                        io_out_quotient  <= next_work;
                        io_out_remainder <= next_rem;
`ifdef SEQ_DIV_DIVZERO_EN
                        divzero          <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    if (io_out_ready) begin
                        state        <= IDLE;
                        io_out_valid <= 1'b0;
                        io_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    io_out_valid <= 1'b0;
                    io_in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule
